// File: rtl/aes_gcm_host_if_if.sv
// Host/core port bundle for the AES-GCM host adapter.
// slave = adapter view, master = host plus core environment view.
interface aes_gcm_host_if_if;
  logic [31:0]  iWr_data;
  logic [2:0]   iWr_sel;
  logic         iWr_valid;
  logic         oWr_ready;
  logic [3:0]   oCore_ctrl;
  logic         oCore_keylen;
  logic [95:0]  oCore_iv;
  logic [255:0] oCore_key;
  logic [127:0] oCore_aad;
  logic [127:0] oCore_block;
  logic [127:0] oCore_tag;
  logic         oCore_iv_valid;
  logic         oCore_key_valid;
  logic         oCore_aad_valid;
  logic         oCore_block_valid;
  logic         oCore_tag_valid;
  logic         iCore_ready;
  logic [127:0] iCore_result;
  logic         iCore_result_valid;
  logic [127:0] iCore_tag;
  logic         iCore_tag_valid;
  logic         iCore_authentic;
  logic [31:0]  oRd_data;
  logic         oRd_sel;
  logic         oRd_last;
  logic         oRd_auth;
  logic         oRd_valid;
  logic         iRd_ready;
  logic         oOverflow;

  modport slave (
    input  iWr_data, iWr_sel, iWr_valid,
    input  iCore_ready, iCore_result, iCore_result_valid,
    input  iCore_tag, iCore_tag_valid, iCore_authentic,
    input  iRd_ready,
    output oWr_ready, oCore_ctrl, oCore_keylen,
    output oCore_iv, oCore_key, oCore_aad,
    output oCore_block, oCore_tag,
    output oCore_iv_valid, oCore_key_valid,
    output oCore_aad_valid, oCore_block_valid,
    output oCore_tag_valid,
    output oRd_data, oRd_sel, oRd_last, oRd_auth,
    output oRd_valid, oOverflow
  );

  modport master (
    output iWr_data, iWr_sel, iWr_valid,
    output iCore_ready, iCore_result, iCore_result_valid,
    output iCore_tag, iCore_tag_valid, iCore_authentic,
    output iRd_ready,
    input  oWr_ready, oCore_ctrl, oCore_keylen,
    input  oCore_iv, oCore_key, oCore_aad,
    input  oCore_block, oCore_tag,
    input  oCore_iv_valid, oCore_key_valid,
    input  oCore_aad_valid, oCore_block_valid,
    input  oCore_tag_valid,
    input  oRd_data, oRd_sel, oRd_last, oRd_auth,
    input  oRd_valid, oOverflow
  );
endinterface

// File: rtl/aes_gcm_host_if.sv
// Word-serial host adapter for the AES-GCM v4 core: assembles 32-bit
// writes into wide core fields and streams result/tag words back.
module aes_gcm_host_if (
  input  logic iClk,
  input  logic iRstn,
  aes_gcm_host_if_if.slave bus
);
  localparam logic [0:0] W_COLLECT = 1'b0;
  localparam logic [0:0] W_COMMIT  = 1'b1;
  localparam logic [1:0] R_IDLE    = 2'd0;
  localparam logic [1:0] R_RES     = 2'd1;
  localparam logic [1:0] R_TAG     = 2'd2;

  logic [0:0]   wst;
  logic         wr_ready;
  logic [2:0]   cur_sel;
  logic [2:0]   cnt;
  logic [2:0]   idx;
  logic [2:0]   last_idx;
  logic [31:0]  shw [8];
  logic [3:0]   ctrl;
  logic         keylen;
  logic [95:0]  iv;
  logic [255:0] key;
  logic [127:0] aad, blk, tag;
  logic         iv_v, key_v, aad_v, blk_v, tag_v;
  logic         acc;

  assign acc = bus.iWr_valid & wr_ready;
  // a select change restarts the field at word 0
  assign idx = (bus.iWr_sel == cur_sel) ? cnt : 3'd0;

  always_comb begin
    last_idx = 3'd3;
    unique case (bus.iWr_sel)
      3'd0:    last_idx = keylen ? 3'd7 : 3'd3;
      3'd1:    last_idx = 3'd2;
      default: last_idx = 3'd3;
    endcase
  end

  always_ff @(posedge iClk or negedge iRstn) begin
    if (!iRstn) begin
      wst      <= W_COLLECT;
      wr_ready <= 1'b0;
      cur_sel  <= '0;
      cnt      <= '0;
      for (int i = 0; i < 8; i++) shw[i] <= '0;
      ctrl     <= '0;
      keylen   <= 1'b0;
      iv       <= '0;
      key      <= '0;
      aad      <= '0;
      blk      <= '0;
      tag      <= '0;
      {iv_v, key_v, aad_v, blk_v, tag_v} <= '0;
    end else begin
      {iv_v, key_v, aad_v, blk_v, tag_v} <= '0;
      unique case (wst)
        W_COLLECT: begin
          wr_ready <= 1'b1;
          if (acc) begin
            cur_sel <= bus.iWr_sel;
            if (bus.iWr_sel >= 3'd5) begin
              cnt <= '0;
              if (bus.iWr_sel == 3'd5) begin
                ctrl   <= bus.iWr_data[3:0];
                keylen <= bus.iWr_data[4];
              end
            end else if (idx == last_idx) begin
              shw[idx] <= bus.iWr_data;
              cnt      <= '0;
              wst      <= W_COMMIT;
              wr_ready <= 1'b0;
            end else begin
              shw[idx] <= bus.iWr_data;
              cnt      <= idx + 3'd1;
            end
          end
        end
        W_COMMIT: begin
          if (bus.iCore_ready) begin
            wst      <= W_COLLECT;
            wr_ready <= 1'b1;
            unique case (cur_sel)
              3'd0: begin
                key <= keylen
                  ? {shw[0], shw[1], shw[2], shw[3],
                     shw[4], shw[5], shw[6], shw[7]}
                  : {shw[0], shw[1], shw[2], shw[3], 128'd0};
                key_v <= 1'b1;
              end
              3'd1: begin
                iv   <= {shw[0], shw[1], shw[2]};
                iv_v <= 1'b1;
              end
              3'd2: begin
                aad   <= {shw[0], shw[1], shw[2], shw[3]};
                aad_v <= 1'b1;
              end
              3'd3: begin
                blk   <= {shw[0], shw[1], shw[2], shw[3]};
                blk_v <= 1'b1;
              end
              3'd4: begin
                tag   <= {shw[0], shw[1], shw[2], shw[3]};
                tag_v <= 1'b1;
              end
              default: ;
            endcase
          end
        end
      endcase
    end
  end

  assign bus.oWr_ready         = wr_ready;
  assign bus.oCore_ctrl        = ctrl;
  assign bus.oCore_keylen      = keylen;
  assign bus.oCore_iv          = iv;
  assign bus.oCore_key         = key;
  assign bus.oCore_aad         = aad;
  assign bus.oCore_block       = blk;
  assign bus.oCore_tag         = tag;
  assign bus.oCore_iv_valid    = iv_v;
  assign bus.oCore_key_valid   = key_v;
  assign bus.oCore_aad_valid   = aad_v;
  assign bus.oCore_block_valid = blk_v;
  assign bus.oCore_tag_valid   = tag_v;

  logic [1:0]   rstate;
  logic [1:0]   rcnt;
  logic [127:0] res_buf, tag_buf;
  logic         res_full, tag_full, tag_auth, ovf;
  logic [127:0] rd_sh;

  always_ff @(posedge iClk or negedge iRstn) begin
    if (!iRstn) begin
      rstate   <= R_IDLE;
      rcnt     <= '0;
      res_buf  <= '0;
      tag_buf  <= '0;
      res_full <= 1'b0;
      tag_full <= 1'b0;
      tag_auth <= 1'b0;
      ovf      <= 1'b0;
    end else begin
      if (bus.iCore_result_valid) begin
        if (!res_full) begin
          res_buf  <= bus.iCore_result;
          res_full <= 1'b1;
        end else ovf <= 1'b1;
      end
      if (bus.iCore_tag_valid) begin
        if (!tag_full) begin
          tag_buf  <= bus.iCore_tag;
          tag_auth <= bus.iCore_authentic;
          tag_full <= 1'b1;
        end else ovf <= 1'b1;
      end
      unique case (1'b1)
        (rstate == R_IDLE): begin
          rcnt <= '0;
          if (res_full) rstate <= R_RES;
          else if (tag_full) rstate <= R_TAG;
        end
        default: begin
          if (bus.iRd_ready) begin
            rcnt <= rcnt + 2'd1;
            if (rcnt == 2'd3) begin
              rstate <= R_IDLE;
              if (rstate == R_RES) res_full <= 1'b0;
              else tag_full <= 1'b0;
            end
          end
        end
      endcase
    end
  end

  always_comb begin
    rd_sh = (rstate == R_TAG) ? tag_buf : res_buf;
    rd_sh = rd_sh << {rcnt, 5'd0};
  end

  assign bus.oRd_valid = (rstate != R_IDLE);
  assign bus.oRd_data  = bus.oRd_valid ? rd_sh[127:96] : 32'd0;
  assign bus.oRd_sel   = (rstate == R_TAG);
  assign bus.oRd_last  = bus.oRd_valid & (rcnt == 2'd3);
  assign bus.oRd_auth  = tag_auth;
  assign bus.oOverflow = ovf;
endmodule

// File: tb/tb_aes_gcm_host_if.sv
// Directed/randomized bench for aes_gcm_host_if with a field-level model.
// Expected core fields and read words are built from the host word lists.
module tb_aes_gcm_host_if;
  logic iClk = 1'b0;
  logic iRstn = 1'b0;
  int tests = 0;
  int fails = 0;
  int n_key = 0, n_iv = 0, n_aad = 0, n_blk = 0, n_tag = 0;
  logic [34:0] q[$];

  aes_gcm_host_if_if bus();
  aes_gcm_host_if dut (.iClk(iClk), .iRstn(iRstn), .bus(bus));

  always #5 iClk = ~iClk;

  always @(posedge iClk) begin
    if (bus.oCore_key_valid)   n_key++;
    if (bus.oCore_iv_valid)    n_iv++;
    if (bus.oCore_aad_valid)   n_aad++;
    if (bus.oCore_block_valid) n_blk++;
    if (bus.oCore_tag_valid)   n_tag++;
  end

  initial begin
    #300000;
    $display("FAIL watchdog obs=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [255:0] obs,
                     input logic [255:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [2:0] s, input logic [31:0] d);
    int n = 0;
    bus.iWr_sel = s;
    bus.iWr_data = d;
    bus.iWr_valid = 1'b1;
    while (!bus.oWr_ready && n < 200) begin
      @(negedge iClk);
      n++;
    end
    if (n >= 200) chk("wr_timeout", 1, 0);
    @(posedge iClk);
    #1;
    bus.iWr_valid = 1'b0;
  endtask

  task automatic push_field(input logic [127:0] v, input logic s,
                            input logic a);
    logic [127:0] t;
    for (int i = 0; i < 4; i++) begin
      t = v >> (96 - 32 * i);
      q.push_back({s, (i == 3) ? 1'b1 : 1'b0, s & a, t[31:0]});
    end
  endtask

  task automatic drain(input int budget);
    int n = 0;
    while (q.size() > 0 && n < budget) begin
      if (bus.oRd_valid)
        chk("rd_word",
            {bus.oRd_sel, bus.oRd_last, bus.oRd_sel & bus.oRd_auth,
             bus.oRd_data}, q[0]);
      bus.iRd_ready = 1'($urandom_range(0, 1));
      if (bus.oRd_valid && bus.iRd_ready) void'(q.pop_front());
      @(negedge iClk);
      n++;
    end
    chk("drain_done", q.size(), 0);
    bus.iRd_ready = 1'b0;
  endtask

  initial begin
    logic [31:0]  w[8];
    logic [255:0] e;
    logic [127:0] r1, r2, t1;
    int k0, k1, n;

    bus.iWr_data = '0;
    bus.iWr_sel = '0;
    bus.iWr_valid = 1'b0;
    bus.iCore_ready = 1'b1;
    bus.iCore_result = '0;
    bus.iCore_result_valid = 1'b0;
    bus.iCore_tag = '0;
    bus.iCore_tag_valid = 1'b0;
    bus.iCore_authentic = 1'b0;
    bus.iRd_ready = 1'b0;

    repeat (3) @(posedge iClk);
    #1;
    chk("rst_wr_ready", bus.oWr_ready, 0);
    chk("rst_key", bus.oCore_key, 0);
    chk("rst_ctrl", {bus.oCore_ctrl, bus.oCore_keylen}, 0);
    chk("rst_rd", {bus.oRd_valid, bus.oRd_data, bus.oOverflow}, 0);
    @(negedge iClk);
    iRstn = 1'b1;
    @(posedge iClk);
    #1;
    chk("ready_after_rst", bus.oWr_ready, 1);

    wr(3'd5, 32'h0000_0013);
    chk("ctrl_keylen", {bus.oCore_ctrl, bus.oCore_keylen}, {4'd3, 1'b1});

    e = '0;
    for (int i = 0; i < 8; i++) begin
      w[i] = 32'h0001_0203 + 32'(i) * 32'h0404_0404;
      e = (e << 32) | 256'(w[i]);
    end
    k0 = n_key;
    for (int i = 0; i < 8; i++) wr(3'd0, w[i]);
    chk("key_v_early", bus.oCore_key_valid, 0);
    @(posedge iClk);
    #1;
    chk("key_v_pulse", bus.oCore_key_valid, 1);
    chk("key256", bus.oCore_key, e);
    @(posedge iClk);
    #1;
    chk("key_v_off", bus.oCore_key_valid, 0);
    chk("key_pulses", n_key - k0, 1);

    wr(3'd5, 32'h0000_0003);
    e = '0;
    for (int i = 0; i < 4; i++) begin
      w[i] = $urandom;
      e = (e << 32) | 256'(w[i]);
    end
    e = e << 128;
    for (int i = 0; i < 4; i++) wr(3'd0, w[i]);
    repeat (2) @(posedge iClk);
    #1;
    chk("key128", bus.oCore_key, e);

    bus.iCore_ready = 1'b0;
    k0 = n_iv;
    e = '0;
    for (int i = 0; i < 3; i++) begin
      w[i] = $urandom;
      e = (e << 32) | 256'(w[i]);
    end
    for (int i = 0; i < 3; i++) wr(3'd1, w[i]);
    n = 0;
    repeat (10) begin
      @(posedge iClk);
      #1;
      if (!bus.oWr_ready) n++;
    end
    chk("stall_ready", n, 10);
    chk("stall_no_iv", n_iv - k0, 0);
    bus.iCore_ready = 1'b1;
    @(posedge iClk);
    #1;
    chk("iv_pulse", bus.oCore_iv_valid, 1);
    chk("iv_data", bus.oCore_iv, e);
    @(posedge iClk);
    #1;
    chk("iv_pulses", n_iv - k0, 1);
    chk("ready_back", bus.oWr_ready, 1);

    k0 = n_blk;
    k1 = n_aad;
    wr(3'd3, $urandom);
    wr(3'd3, $urandom);
    e = '0;
    for (int i = 0; i < 4; i++) begin
      w[i] = $urandom;
      e = (e << 32) | 256'(w[i]);
    end
    for (int i = 0; i < 4; i++) wr(3'd2, w[i]);
    repeat (2) @(posedge iClk);
    #1;
    chk("aad_data", bus.oCore_aad, e);
    chk("aad_pulses", n_aad - k1, 1);
    chk("blk_unchanged", bus.oCore_block, 0);
    chk("blk_no_pulse", n_blk - k0, 0);

    k0 = n_tag;
    e = '0;
    for (int i = 0; i < 4; i++) begin
      w[i] = $urandom;
      e = (e << 32) | 256'(w[i]);
    end
    for (int i = 0; i < 4; i++) wr(3'd4, w[i]);
    repeat (2) @(posedge iClk);
    #1;
    chk("tag_data", bus.oCore_tag, e);
    k1 = n_key + n_iv + n_aad + n_blk + n_tag;
    wr(3'd6, $urandom);
    wr(3'd7, $urandom);
    repeat (3) @(posedge iClk);
    #1;
    chk("ignored_sel", n_key + n_iv + n_aad + n_blk + n_tag, k1);
    chk("ignored_ctrl", {bus.oCore_ctrl, bus.oCore_keylen}, {4'd3, 1'b0});

    r1 = {$urandom, $urandom, $urandom, $urandom};
    t1 = {$urandom, $urandom, $urandom, $urandom};
    @(negedge iClk);
    bus.iCore_result = r1;
    bus.iCore_tag = t1;
    bus.iCore_authentic = 1'b1;
    bus.iCore_result_valid = 1'b1;
    bus.iCore_tag_valid = 1'b1;
    push_field(r1, 1'b0, 1'b1);
    push_field(t1, 1'b1, 1'b1);
    @(negedge iClk);
    bus.iCore_result_valid = 1'b0;
    bus.iCore_tag_valid = 1'b0;
    bus.iCore_authentic = 1'b0;
    chk("rd_lat_c1", bus.oRd_valid, 0);
    @(negedge iClk);
    chk("rd_lat_c2", bus.oRd_valid, 1);
    drain(400);

    r1 = {$urandom, $urandom, $urandom, $urandom};
    r2 = {$urandom, $urandom, $urandom, $urandom};
    bus.iCore_result = r1;
    bus.iCore_result_valid = 1'b1;
    push_field(r1, 1'b0, 1'b0);
    @(negedge iClk);
    bus.iCore_result_valid = 1'b0;
    chk("ovf_clear", bus.oOverflow, 0);
    @(negedge iClk);
    bus.iCore_result = r2;
    bus.iCore_result_valid = 1'b1;
    @(negedge iClk);
    bus.iCore_result_valid = 1'b0;
    chk("ovf_set", bus.oOverflow, 1);
    drain(400);
    n = 0;
    repeat (4) begin
      @(negedge iClk);
      if (bus.oRd_valid) n++;
    end
    chk("dropped_result", n, 0);
    chk("ovf_sticky", bus.oOverflow, 1);

    wr(3'd5, 32'h0000_0010);
    for (int i = 0; i < 5; i++) wr(3'd0, $urandom);
    @(negedge iClk);
    iRstn = 1'b0;
    #1;
    chk("arst_key", bus.oCore_key, 0);
    chk("arst_ctrl", {bus.oCore_ctrl, bus.oCore_keylen, bus.oCore_aad}, 0);
    chk("arst_flags", {bus.oWr_ready, bus.oRd_valid, bus.oOverflow}, 0);
    @(negedge iClk);
    iRstn = 1'b1;
    @(posedge iClk);
    #1;
    k0 = n_key;
    wr(3'd5, 32'h0000_0010);
    e = '0;
    for (int i = 0; i < 8; i++) begin
      w[i] = $urandom;
      e = (e << 32) | 256'(w[i]);
    end
    for (int i = 0; i < 8; i++) wr(3'd0, w[i]);
    repeat (2) @(posedge iClk);
    #1;
    chk("key_after_rst", bus.oCore_key, e);
    chk("key_pulse_rst", n_key - k0, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
